// File: rtl/blit_addrgen_mc_if.sv
// Command/result bundle between the blit sequencer, the address generator
// and the memory request stage.
interface blit_addrgen_mc_if #(
  parameter int COORD_W = 16,
  parameter int SRC_AW  = 32,
  parameter int DEST_AW = 26
);
  logic               in_valid;
  logic               in_ready;
  logic               in_run_line;
  logic               in_run_rect;
  logic [COORD_W-1:0] in_line_x;
  logic [COORD_W-1:0] in_line_y;
  logic [COORD_W-1:0] in_rect_dest_x;
  logic [COORD_W-1:0] in_rect_dest_y;
  logic [COORD_W-1:0] in_src_x;
  logic [COORD_W-1:0] in_src_y;
  logic [1:0]         in_src_fmt;
  logic [1:0]         in_dest_fmt;
  logic [SRC_AW-1:0]  in_src_base;
  logic [COORD_W-1:0] in_src_bpr;
  logic [DEST_AW-1:0] in_dest_base;
  logic [COORD_W-1:0] in_dest_bpr;

  logic               out_valid;
  logic               out_ready;
  logic [SRC_AW-1:0]  out_src_addr;
  logic [DEST_AW-1:0] out_dest_addr;
  logic [2:0]         out_src_bit;
  logic               out_write_en;

  modport master (
    output in_valid, in_run_line, in_run_rect, in_line_x, in_line_y,
           in_rect_dest_x, in_rect_dest_y, in_src_x, in_src_y, in_src_fmt,
           in_dest_fmt, in_src_base, in_src_bpr, in_dest_base, in_dest_bpr,
           out_ready,
    input  in_ready, out_valid, out_src_addr, out_dest_addr, out_src_bit,
           out_write_en
  );

  modport slave (
    input  in_valid, in_run_line, in_run_rect, in_line_x, in_line_y,
           in_rect_dest_x, in_rect_dest_y, in_src_x, in_src_y, in_src_fmt,
           in_dest_fmt, in_src_base, in_src_bpr, in_dest_base, in_dest_bpr,
           out_ready,
    output in_ready, out_valid, out_src_addr, out_dest_addr, out_src_bit,
           out_write_en
  );
endinterface

// File: rtl/blit_addrgen_mc.sv
// Two-stage blitter address generator: row products and clip test in stage A,
// final address sums in stage B, elastic valid/ready between the stages.
module blit_addrgen_mc #(
  parameter int COORD_W = 16,
  parameter int SRC_AW  = 32,
  parameter int DEST_AW = 26,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  blit_addrgen_mc_if.slave   bus,
  input  logic [COORD_W-1:0] clip_x1,
  input  logic [COORD_W-1:0] clip_y1,
  input  logic [COORD_W-1:0] clip_x2,
  input  logic [COORD_W-1:0] clip_y2,
  output logic [CNT_W-1:0]   clip_count,
  input  logic               clip_count_clr
);

  localparam int XW = COORD_W + 2;
  localparam int PW = 2 * COORD_W;
  // Two spare bits absorb the carries of the three-operand sums.
  localparam int SRC_SW  = ((SRC_AW  > PW) ? SRC_AW  : PW) + 2;
  localparam int DEST_SW = ((DEST_AW > PW) ? DEST_AW : PW) + 2;

  function automatic logic [XW-1:0] scale_x(input logic [COORD_W-1:0] x,
                                            input logic [1:0] fmt);
    case (fmt)
      2'd0:    scale_x = XW'(x >> 3);
      2'd1:    scale_x = XW'(x);
      2'd2:    scale_x = XW'(x) << 1;
      2'd3:    scale_x = XW'(x) << 2;
      default: scale_x = XW'(x);
    endcase
  endfunction

  logic               a_valid_r;
  logic [SRC_AW-1:0]  a_src_base_r;
  logic [DEST_AW-1:0] a_dest_base_r;
  logic [PW-1:0]      a_src_prod_r;
  logic [PW-1:0]      a_dest_prod_r;
  logic [XW-1:0]      a_sx_r;
  logic [XW-1:0]      a_dx_r;
  logic [2:0]         a_bit_r;
  logic               a_we_r;

  logic               b_valid_r;
  logic [SRC_AW-1:0]  b_src_addr_r;
  logic [DEST_AW-1:0] b_dest_addr_r;
  logic [2:0]         b_bit_r;
  logic               b_we_r;

  logic [CNT_W-1:0]   clip_count_r;

  logic               run_s;
  logic [COORD_W-1:0] dx_s;
  logic [COORD_W-1:0] dy_s;
  logic               we_s;
  logic [1:0]         dest_fmt_s;
  logic [XW-1:0]      sx_s;
  logic [XW-1:0]      dxs_s;
  logic [2:0]         bit_s;
  logic               b_free_s;
  logic               in_ready_s;
  logic               a_load_s;
  logic               b_load_s;
  logic               clip_inc_s;
  logic [SRC_SW-1:0]  src_sum_s;
  logic [DEST_SW-1:0] dest_sum_s;
  logic               unused_sum_bits_s;

  assign b_free_s   = !b_valid_r || bus.out_ready;
  assign in_ready_s = !a_valid_r || b_free_s;
  assign a_load_s   = bus.in_valid && in_ready_s;
  assign b_load_s   = a_valid_r && b_free_s;
  assign run_s      = bus.in_run_line || bus.in_run_rect;

  // Dest coordinate select (line wins), format scaling and clip decision.
  always_comb begin
    dx_s       = bus.in_rect_dest_x;
    dy_s       = bus.in_rect_dest_y;
    dest_fmt_s = bus.in_dest_fmt;
    bit_s      = 3'd0;
    if (bus.in_run_line) begin
      dx_s = bus.in_line_x;
      dy_s = bus.in_line_y;
    end else begin
      dx_s = bus.in_rect_dest_x;
      dy_s = bus.in_rect_dest_y;
    end
    if (bus.in_dest_fmt == 2'd0) begin
      dest_fmt_s = 2'd1;
    end else begin
      dest_fmt_s = bus.in_dest_fmt;
    end
    if (bus.in_src_fmt == 2'd0) begin
      bit_s = bus.in_src_x[2:0];
    end else begin
      bit_s = 3'd0;
    end
    sx_s  = scale_x(bus.in_src_x, bus.in_src_fmt);
    dxs_s = scale_x(dx_s, dest_fmt_s);
    we_s  = run_s && (dx_s >= clip_x1) && (dx_s < clip_x2)
                  && (dy_s >= clip_y1) && (dy_s < clip_y2);
  end

  assign clip_inc_s = a_load_s && run_s && !we_s;

  // Sums are formed wide and truncated, giving modulo-2^AW wrap.
  assign src_sum_s  = SRC_SW'(a_src_base_r) + SRC_SW'(a_sx_r) + SRC_SW'(a_src_prod_r);
  assign dest_sum_s = DEST_SW'(a_dest_base_r) + DEST_SW'(a_dx_r) + DEST_SW'(a_dest_prod_r);
  assign unused_sum_bits_s = ^{src_sum_s[SRC_SW-1:SRC_AW], dest_sum_s[DEST_SW-1:DEST_AW]};

  // Stage A: capture products, scaled x and clip result on acceptance.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_valid_r     <= 1'b0;
      a_src_base_r  <= '0;
      a_dest_base_r <= '0;
      a_src_prod_r  <= '0;
      a_dest_prod_r <= '0;
      a_sx_r        <= '0;
      a_dx_r        <= '0;
      a_bit_r       <= 3'd0;
      a_we_r        <= 1'b0;
    end else begin
      if (a_load_s) begin
        a_valid_r <= 1'b1;
      end else if (b_load_s) begin
        a_valid_r <= 1'b0;
      end
      if (a_load_s) begin
        a_src_base_r  <= bus.in_src_base;
        a_dest_base_r <= bus.in_dest_base;
        a_src_prod_r  <= PW'(bus.in_src_y) * PW'(bus.in_src_bpr);
        a_dest_prod_r <= PW'(dy_s) * PW'(bus.in_dest_bpr);
        a_sx_r        <= sx_s;
        a_dx_r        <= dxs_s;
        a_bit_r       <= bit_s;
        a_we_r        <= we_s;
      end
    end
  end

  // Stage B: output register, held while the consumer stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      b_valid_r     <= 1'b0;
      b_src_addr_r  <= '0;
      b_dest_addr_r <= '0;
      b_bit_r       <= 3'd0;
      b_we_r        <= 1'b0;
    end else begin
      if (b_load_s) begin
        b_valid_r <= 1'b1;
      end else if (bus.out_ready) begin
        b_valid_r <= 1'b0;
      end
      if (b_load_s) begin
        b_src_addr_r  <= src_sum_s[SRC_AW-1:0];
        b_dest_addr_r <= dest_sum_s[DEST_AW-1:0];
        b_bit_r       <= a_bit_r;
        b_we_r        <= a_we_r;
      end
    end
  end

  // Saturating clipped-pixel counter; clear and increment together yield 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      clip_count_r <= '0;
    end else if (clip_count_clr) begin
      clip_count_r <= clip_inc_s ? CNT_W'(1) : '0;
    end else if (clip_inc_s && (clip_count_r != {CNT_W{1'b1}})) begin
      clip_count_r <= clip_count_r + CNT_W'(1);
    end
  end

  assign bus.in_ready      = in_ready_s;
  assign bus.out_valid     = b_valid_r;
  assign bus.out_src_addr  = b_src_addr_r;
  assign bus.out_dest_addr = b_dest_addr_r;
  assign bus.out_src_bit   = b_bit_r;
  assign bus.out_write_en  = b_we_r;
  assign clip_count        = clip_count_r;

endmodule

// File: tb/tb_blit_addrgen_mc.sv
// Directed bench for blit_addrgen_mc: vector table plus backpressure,
// counter saturation and mid-flight reset sequences.
module tb_blit_addrgen_mc;

  logic        clock;
  logic        reset;
  logic [15:0] clip_x1, clip_y1, clip_x2, clip_y2;
  logic        clip_count_clr;
  logic [15:0] clip_count;
  logic [3:0]  clip_count_small;

  int checks = 0;
  int errors = 0;

  blit_addrgen_mc_if bif ();
  blit_addrgen_mc_if bif2 ();

  blit_addrgen_mc dut (
    .clock(clock), .reset(reset), .bus(bif),
    .clip_x1(clip_x1), .clip_y1(clip_y1), .clip_x2(clip_x2), .clip_y2(clip_y2),
    .clip_count(clip_count), .clip_count_clr(clip_count_clr)
  );

  // Narrow-counter copy sees the identical command stream to reach saturation quickly.
  blit_addrgen_mc #(.CNT_W(4)) dut_small (
    .clock(clock), .reset(reset), .bus(bif2),
    .clip_x1(clip_x1), .clip_y1(clip_y1), .clip_x2(clip_x2), .clip_y2(clip_y2),
    .clip_count(clip_count_small), .clip_count_clr(clip_count_clr)
  );

  assign bif2.in_valid       = bif.in_valid;
  assign bif2.in_run_line    = bif.in_run_line;
  assign bif2.in_run_rect    = bif.in_run_rect;
  assign bif2.in_line_x      = bif.in_line_x;
  assign bif2.in_line_y      = bif.in_line_y;
  assign bif2.in_rect_dest_x = bif.in_rect_dest_x;
  assign bif2.in_rect_dest_y = bif.in_rect_dest_y;
  assign bif2.in_src_x       = bif.in_src_x;
  assign bif2.in_src_y       = bif.in_src_y;
  assign bif2.in_src_fmt     = bif.in_src_fmt;
  assign bif2.in_dest_fmt    = bif.in_dest_fmt;
  assign bif2.in_src_base    = bif.in_src_base;
  assign bif2.in_src_bpr     = bif.in_src_bpr;
  assign bif2.in_dest_base   = bif.in_dest_base;
  assign bif2.in_dest_bpr    = bif.in_dest_bpr;
  assign bif2.out_ready      = bif.out_ready;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rl, rr;
    logic [15:0] lx, ly, rx, ry, sx, sy;
    logic [1:0]  sf, df;
    logic [31:0] sb;
    logic [15:0] sbpr;
    logic [25:0] db;
    logic [15:0] dbpr;
    logic [15:0] cx1, cy1, cx2, cy2;
    logic [31:0] e_src;
    logic [25:0] e_dst;
    logic [2:0]  e_bit;
    logic        e_we;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_cmd(input vec_t v);
    bif.in_run_line    = v.rl;
    bif.in_run_rect    = v.rr;
    bif.in_line_x      = v.lx;
    bif.in_line_y      = v.ly;
    bif.in_rect_dest_x = v.rx;
    bif.in_rect_dest_y = v.ry;
    bif.in_src_x       = v.sx;
    bif.in_src_y       = v.sy;
    bif.in_src_fmt     = v.sf;
    bif.in_dest_fmt    = v.df;
    bif.in_src_base    = v.sb;
    bif.in_src_bpr     = v.sbpr;
    bif.in_dest_base   = v.db;
    bif.in_dest_bpr    = v.dbpr;
    clip_x1 = v.cx1; clip_y1 = v.cy1; clip_x2 = v.cx2; clip_y2 = v.cy2;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Single command with out_ready high: check 2-cycle latency and all fields.
  task automatic run_vec(input vec_t v, input int idx);
    set_cmd(v);
    bif.out_ready = 1'b1;
    bif.in_valid  = 1'b1;
    chk($sformatf("v%0d_in_ready", idx), bif.in_ready, 1'b1);
    tick();
    bif.in_valid = 1'b0;
    chk($sformatf("v%0d_valid_early", idx), bif.out_valid, 1'b0);
    tick();
    chk($sformatf("v%0d_valid", idx), bif.out_valid, 1'b1);
    chk($sformatf("v%0d_src", idx), bif.out_src_addr, v.e_src);
    chk($sformatf("v%0d_dst", idx), bif.out_dest_addr, v.e_dst);
    chk($sformatf("v%0d_bit", idx), bif.out_src_bit, v.e_bit);
    chk($sformatf("v%0d_we", idx), bif.out_write_en, v.e_we);
    chk($sformatf("v%0d_cnt", idx), clip_count, v.e_cnt);
    tick();
  endtask

  function automatic vec_t clipped_cmd();
    vec_t v;
    v = '{1'b0, 1'b1, 16'd0, 16'd0, 16'd9, 16'd3, 16'd0, 16'd0, 2'd1, 2'd1,
          32'd0, 16'd0, 26'd0, 16'd0, 16'd8, 16'd0, 16'd8, 16'd240,
          32'd0, 26'd9, 3'd0, 1'b0, 16'd0};
    return v;
  endfunction

  function automatic vec_t bp_cmd(input int i);
    vec_t v;
    v = '{1'b0, 1'b1, 16'd0, 16'd0, 16'(i + 1), 16'd0, 16'(i), 16'd0, 2'd1, 2'd1,
          32'h100, 16'd0, 26'h40, 16'd0, 16'd0, 16'd0, 16'd320, 16'd240,
          32'h100 + 32'(i), 26'h40 + 26'(i + 1), 3'd0, 1'b1, 16'd0};
    return v;
  endfunction

  task automatic stream_clipped(input int n);
    set_cmd(clipped_cmd());
    bif.out_ready = 1'b1;
    bif.in_valid  = 1'b1;
    repeat (n) tick();
    bif.in_valid = 1'b0;
    repeat (3) tick();
  endtask

  logic [31:0] exp_src_q[$];
  logic [25:0] exp_dst_q[$];
  int sent, rcvd, occ;

  initial begin
    //           rl rr  lx  ly  rx  ry  sx  sy  sf df  sb  sbpr  db  dbpr  clip  e_src e_dst bit we cnt
    vecs[0]  = '{1'b0, 1'b1, 16'd0, 16'd0, 16'd10, 16'd3, 16'd5, 16'd2, 2'd1, 2'd1,
                 32'h1000, 16'd640, 26'h20000, 16'd320, 16'd0, 16'd0, 16'd320, 16'd240,
                 32'h1505, 26'h203CA, 3'd0, 1'b1, 16'd0};
    vecs[1]  = '{1'b1, 1'b1, 16'd4, 16'd0, 16'd500, 16'd500, 16'd13, 16'd1, 2'd0, 2'd3,
                 32'd0, 16'd16, 26'd0, 16'd100, 16'd0, 16'd0, 16'd320, 16'd240,
                 32'd17, 26'd16, 3'd5, 1'b1, 16'd0};
    vecs[2]  = '{1'b0, 1'b1, 16'd0, 16'd0, 16'd320, 16'd0, 16'd3, 16'd0, 2'd2, 2'd1,
                 32'h100, 16'd8, 26'd0, 16'd50, 16'd0, 16'd0, 16'd320, 16'd240,
                 32'h106, 26'd320, 3'd0, 1'b0, 16'd1};
    vecs[3]  = '{1'b0, 1'b1, 16'd0, 16'd0, 16'd319, 16'd0, 16'd7, 16'd2, 2'd3, 2'd1,
                 32'd0, 16'd10, 26'd0, 16'd50, 16'd0, 16'd0, 16'd320, 16'd240,
                 32'd48, 26'd319, 3'd0, 1'b1, 16'd1};
    vecs[4]  = '{1'b0, 1'b1, 16'd0, 16'd0, 16'd2, 16'd0, 16'd1, 16'd0, 2'd1, 2'd1,
                 32'hFFFFFFFF, 16'd4, 26'h3FFFFFF, 16'd8, 16'd0, 16'd0, 16'd320, 16'd240,
                 32'h0, 26'h1, 3'd0, 1'b1, 16'd1};
    vecs[5]  = '{1'b0, 1'b0, 16'd9, 16'd9, 16'd1, 16'd1, 16'd7, 16'd0, 2'd0, 2'd2,
                 32'h20, 16'd4, 26'h10, 16'd4, 16'd0, 16'd0, 16'd320, 16'd240,
                 32'h20, 26'h16, 3'd7, 1'b0, 16'd1};
    vecs[6]  = '{1'b0, 1'b1, 16'd0, 16'd0, 16'd5, 16'hFFFF, 16'd0, 16'hFFFF, 2'd1, 2'd0,
                 32'd1, 16'hFFFF, 26'd0, 16'hFFFF, 16'd0, 16'd0, 16'd320, 16'd240,
                 32'hFFFE0002, 26'h3FE0006, 3'd0, 1'b0, 16'd2};
    vecs[7]  = '{1'b0, 1'b1, 16'd0, 16'd0, 16'd8, 16'd4, 16'd0, 16'd0, 2'd1, 2'd1,
                 32'd0, 16'd0, 26'd0, 16'd0, 16'd8, 16'd4, 16'd16, 16'd12,
                 32'd0, 26'd8, 3'd0, 1'b1, 16'd2};
    vecs[8]  = '{1'b0, 1'b1, 16'd0, 16'd0, 16'd7, 16'd4, 16'd0, 16'd0, 2'd1, 2'd1,
                 32'd0, 16'd0, 26'd0, 16'd0, 16'd8, 16'd4, 16'd16, 16'd12,
                 32'd0, 26'd7, 3'd0, 1'b0, 16'd3};
    vecs[9]  = '{1'b0, 1'b1, 16'd0, 16'd0, 16'd15, 16'd11, 16'd0, 16'd0, 2'd1, 2'd1,
                 32'd0, 16'd0, 26'd0, 16'd0, 16'd8, 16'd4, 16'd16, 16'd12,
                 32'd0, 26'd15, 3'd0, 1'b1, 16'd3};
    vecs[10] = '{1'b0, 1'b1, 16'd0, 16'd0, 16'd8, 16'd12, 16'd0, 16'd0, 2'd1, 2'd1,
                 32'd0, 16'd0, 26'd0, 16'd0, 16'd8, 16'd4, 16'd16, 16'd12,
                 32'd0, 26'd8, 3'd0, 1'b0, 16'd4};
    vecs[11] = '{1'b1, 1'b0, 16'd16, 16'd4, 16'd9, 16'd5, 16'd0, 16'd0, 2'd1, 2'd1,
                 32'd0, 16'd0, 26'd0, 16'd0, 16'd8, 16'd4, 16'd16, 16'd12,
                 32'd0, 26'd16, 3'd0, 1'b0, 16'd5};

    reset = 1'b1;
    clip_count_clr = 1'b0;
    bif.in_valid = 1'b0;
    bif.out_ready = 1'b1;
    set_cmd(vecs[0]);
    repeat (2) tick();
    chk("rst_valid", bif.out_valid, 1'b0);
    chk("rst_src", bif.out_src_addr, 32'd0);
    chk("rst_dst", bif.out_dest_addr, 26'd0);
    chk("rst_bit", bif.out_src_bit, 3'd0);
    chk("rst_we", bif.out_write_en, 1'b0);
    chk("rst_cnt", clip_count, 16'd0);
    chk("rst_in_ready", bif.in_ready, 1'b1);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    clip_count_clr = 1'b1;
    tick();
    clip_count_clr = 1'b0;
    chk("clr_cnt", clip_count, 16'd0);
    chk("clr_cnt_small", clip_count_small, 4'd0);

    stream_clipped(11);
    chk("empty_win_cnt", clip_count, 16'd11);
    chk("empty_win_cnt_small", clip_count_small, 4'd11);
    stream_clipped(5);
    chk("cnt_16", clip_count, 16'd16);
    chk("cnt_sat_small", clip_count_small, 4'd15);

    set_cmd(clipped_cmd());
    bif.in_valid = 1'b1;
    clip_count_clr = 1'b1;
    tick();
    bif.in_valid = 1'b0;
    clip_count_clr = 1'b0;
    chk("clr_inc_cnt", clip_count, 16'd1);
    chk("clr_inc_cnt_small", clip_count_small, 4'd1);
    repeat (3) tick();

    // Backpressure: 6 back-to-back commands, consumer stalls on cycles 3..5.
    sent = 0; rcvd = 0; occ = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      bif.out_ready = !(cyc >= 3 && cyc <= 5);
      if (sent < 6) begin
        set_cmd(bp_cmd(sent));
        bif.in_valid = 1'b1;
      end else begin
        bif.in_valid = 1'b0;
      end
      #1;
      chk($sformatf("bp_in_ready_c%0d", cyc), bif.in_ready, (occ < 2) || bif.out_ready);
      if (bif.out_valid) begin
        if (exp_src_q.size() == 0) begin
          chk($sformatf("bp_spurious_c%0d", cyc), bif.out_valid, 1'b0);
        end else begin
          chk($sformatf("bp_src_c%0d", cyc), bif.out_src_addr, exp_src_q[0]);
          chk($sformatf("bp_dst_c%0d", cyc), bif.out_dest_addr, exp_dst_q[0]);
          chk($sformatf("bp_we_c%0d", cyc), bif.out_write_en, 1'b1);
          if (bif.out_ready) begin
            void'(exp_src_q.pop_front());
            void'(exp_dst_q.pop_front());
            rcvd++;
          end
        end
      end
      if (bif.in_valid && bif.in_ready) begin
        exp_src_q.push_back(32'h100 + 32'(sent));
        exp_dst_q.push_back(26'h40 + 26'(sent + 1));
        sent++;
        occ++;
      end
      if (bif.out_valid && bif.out_ready) occ--;
      tick();
    end
    chk("bp_sent", sent, 6);
    chk("bp_rcvd", rcvd, 6);

    // Reset with two clipped commands in flight.
    bif.out_ready = 1'b1;
    set_cmd(clipped_cmd());
    bif.in_valid = 1'b1;
    repeat (2) tick();
    bif.in_valid = 1'b0;
    chk("pre_rst_valid", bif.out_valid, 1'b1);
    chk("pre_rst_cnt", clip_count, 16'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", bif.out_valid, 1'b0);
    chk("mid_rst_cnt", clip_count, 16'd0);
    chk("mid_rst_in_ready", bif.in_ready, 1'b1);
    tick();
    chk("post_rst_no_ghost", bif.out_valid, 1'b0);
    run_vec(vecs[0], 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
